// File: rtl/signed_addsub_seq_pkg.sv
// Shared definitions for the sliced signed add/subtract unit.
package signed_addsub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned num_slices(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Saturation limits of a width-bit signed value, as 64-bit signed numbers.
   function automatic longint sat_max(input int unsigned width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int unsigned width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/signed_addsub_seq_chunk_adder.sv
// CHUNK-bit ripple adder built from full-adder cells; also exposes the carry
// into its top bit so the caller can form the signed overflow flag.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
   parameter int unsigned CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_top
);
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fulladder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[CHUNK];
   assign c_top = c[CHUNK-1];
endmodule

// File: rtl/signed_addsub_seq.sv
// Multi-cycle signed add/subtract: processes CHUNK bits per cycle through one
// shared chunk_adder, then publishes a sign-extended, optionally saturated result.
module signed_addsub_seq
   import signed_addsub_seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHUNK     = 2,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic                 sat_en,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 busy,
   output logic                 done,
   output logic [OUT_WIDTH-1:0] s,
   output logic                 ovf,
   output logic                 zero,
   output logic                 neg
);
   localparam int unsigned K     = num_slices(WIDTH, CHUNK);
   localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0]     LAST  = IDX_W'(K - 1);
   localparam logic [OUT_WIDTH-1:0] S_MAX = OUT_WIDTH'(sat_max(WIDTH));
   localparam logic [OUT_WIDTH-1:0] S_MIN = OUT_WIDTH'(sat_min(WIDTH));

   if ((WIDTH % CHUNK) != 0 || OUT_WIDTH < WIDTH + 1 || WIDTH < 2) begin : g_bad_params
      $error("signed_addsub_seq: WIDTH must be >=2 and a multiple of CHUNK, OUT_WIDTH >= WIDTH+1");
   end

   state_t           state_q, state_d;
   logic             accept_c;
   logic [WIDTH-1:0] x_q, y_q, sum_q;
   logic             carry_q, sat_q;
   logic [IDX_W-1:0] idx_q;

   logic [CHUNK-1:0]     x_sl_c, y_sl_c, sum_sl_c;
   logic                 cout_c, c_top_c, ovf_c;
   logic [WIDTH-1:0]     sum_full_c;
   logic [WIDTH:0]       exact_c;
   logic [OUT_WIDTH-1:0] res_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; start is only honoured outside RUN
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (idx_q == LAST) state_d = DONE;
         end
         DONE: begin
            if (start) begin
               accept_c = 1'b1;
               state_d  = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Slice selection, final assembly, overflow and saturation
   always_comb begin
      x_sl_c     = x_q[int'(idx_q)*CHUNK +: CHUNK];
      y_sl_c     = y_q[int'(idx_q)*CHUNK +: CHUNK];
      sum_full_c = sum_q;
      sum_full_c[int'(idx_q)*CHUNK +: CHUNK] = sum_sl_c;
      ovf_c   = c_top_c ^ cout_c;
      exact_c = {x_q[WIDTH-1] ^ y_q[WIDTH-1] ^ cout_c, sum_full_c};
      if (sat_q && ovf_c) res_c = x_q[WIDTH-1] ? S_MIN : S_MAX;
      else                res_c = OUT_WIDTH'($signed(exact_c));
   end

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (x_sl_c),
      .b     (y_sl_c),
      .cin   (carry_q),
      .sum   (sum_sl_c),
      .cout  (cout_c),
      .c_top (c_top_c)
   );

   // Operand latch, slice accumulation and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         sat_q   <= 1'b0;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
         neg     <= 1'b0;
      end else begin
         busy <= (state_d == RUN);
         done <= (state_d == DONE);
         if (accept_c) begin
            x_q     <= x;
            y_q     <= op_sub ? ~y : y;
            carry_q <= op_sub;
            sat_q   <= sat_en;
            sum_q   <= '0;
            idx_q   <= '0;
         end else if (state_q == RUN) begin
            sum_q   <= sum_full_c;
            carry_q <= cout_c;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
               s    <= res_c;
               ovf  <= ovf_c;
               zero <= (res_c == '0);
               neg  <= res_c[OUT_WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_signed_addsub_seq.sv
// Self-checking bench: per-cycle behavioural model plus directed literal cases
// and a randomized soak with mid-operation resets.
module tb_signed_addsub_seq;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned CHUNK     = 2;
   localparam int unsigned OUT_WIDTH = 16;
   localparam int          K         = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 op_sub = 1'b0;
   logic                 sat_en = 1'b0;
   logic [WIDTH-1:0]     x = '0;
   logic [WIDTH-1:0]     y = '0;
   logic                 busy, done, ovf, zero, neg;
   logic [OUT_WIDTH-1:0] s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   signed_addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .OUT_WIDTH(OUT_WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .sat_en (sat_en),
      .x      (x),
      .y      (y),
      .busy   (busy),
      .done   (done),
      .s      (s),
      .ovf    (ovf),
      .zero   (zero),
      .neg    (neg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Behavioural model: one pending operation with its due cycle, plus held outputs
   bit              pend = 0;
   int              done_at = 0;
   logic [15:0]     p_s = '0, h_s = '0;
   bit              p_ovf = 0, h_ovf = 0, h_zero = 0, e_done = 0;
   int              xi, yi, ei, ri;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 0; h_s = '0; h_ovf = 0; h_zero = 0;
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_done", 64'(done), 64'(0));
         chk("rst_s",    64'(s),    64'(0));
         chk("rst_flags", 64'({ovf, zero, neg}), 64'(0));
      end else begin
         e_done = pend && (cyc == done_at);
         if (e_done) begin
            h_s = p_s; h_ovf = p_ovf; h_zero = (p_s == 16'h0000); pend = 0;
         end
         chk("m_done", 64'(done), 64'(e_done));
         chk("m_busy", 64'(busy), 64'(pend));
         chk("m_s",    64'(s),    64'(h_s));
         chk("m_ovf",  64'(ovf),  64'(h_ovf));
         chk("m_zero", 64'(zero), 64'(h_zero));
         chk("m_neg",  64'(neg),  64'(h_s[15]));
         if (start && !pend) begin
            xi = int'($signed(x));
            yi = int'($signed(y));
            ei = op_sub ? xi - yi : xi + yi;
            p_ovf = (ei > 127) || (ei < -128);
            ri = (sat_en && p_ovf) ? ((xi < 0) ? -128 : 127) : ei;
            p_s = 16'(ri);
            pend = 1;
            done_at = cyc + K + 1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output bit seen);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic sat, input logic [15:0] es, input logic eovf,
                         input string name);
      int t0;
      bit seen;
      x = a; y = b; op_sub = sub; sat_en = sat; start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
      wait_done(seen);
      chk({name, "_done_seen"}, 64'(seen), 64'(1));
      if (seen) begin
         chk({name, "_latency"}, 64'(cyc - t0), 64'(K + 1));
         chk({name, "_s"},       64'(s),        64'(es));
         chk({name, "_ovf"},     64'(ovf),      64'(eovf));
      end
      tick();
   endtask

   initial begin
      int t0, n_done;
      bit seen;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      run_op(8'd100, 8'd50, 1'b0, 1'b0, 16'h0096, 1'b1, "add_ovf");
      chk("add_ovf_flags", 64'({zero, neg}), 64'(0));
      run_op(8'd100, 8'd50, 1'b0, 1'b1, 16'h007F, 1'b1, "add_sat");
      run_op(8'h80,  8'd1,  1'b1, 1'b1, 16'hFF80, 1'b1, "sub_sat_min");
      chk("sub_sat_min_neg", 64'(neg), 64'(1));
      run_op(8'h80,  8'd1,  1'b1, 1'b0, 16'hFF7F, 1'b1, "sub_nosat_min");
      run_op(8'd5,   8'd5,  1'b1, 1'b0, 16'h0000, 1'b0, "sub_zero");
      chk("sub_zero_flag", 64'(zero), 64'(1));
      run_op(8'h80,  8'h80, 1'b1, 1'b0, 16'h0000, 1'b0, "min_minus_min");
      run_op(8'hFD,  8'd1,  1'b0, 1'b0, 16'hFFFE, 1'b0, "neg_add");
      chk("neg_add_neg", 64'(neg), 64'(1));
      run_op(8'd0,   8'h80, 1'b1, 1'b1, 16'h007F, 1'b1, "zero_minus_min_sat");

      // Back-to-back via start held through DONE, with x toggled during RUN
      x = 8'd7; y = 8'd1; op_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
      t0 = cyc;
      tick();
      x = 8'd2; y = 8'd2;
      wait_done(seen);
      chk("b2b_a_seen", 64'(seen), 64'(1));
      chk("b2b_a_lat",  64'(cyc - t0), 64'(5));
      chk("b2b_a_s",    64'(s), 64'(16'h0008));
      tick();
      start = 1'b0;
      x = 8'h55;
      wait_done(seen);
      chk("b2b_b_seen", 64'(seen), 64'(1));
      chk("b2b_b_lat",  64'(cyc - t0), 64'(10));
      chk("b2b_b_s",    64'(s), 64'(16'h0004));
      tick();

      // start pulse during RUN is ignored
      x = 8'd3; y = 8'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk("run_start_ignored", 64'(n_done), 64'(1));
      tick();

      // Reset mid-RUN aborts with no done
      x = 8'd5; y = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_s",    64'(s), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      tick();
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk("abort_no_done", 64'(n_done), 64'(0));
      tick();
      run_op(8'd1, 8'd1, 1'b0, 1'b0, 16'h0002, 1'b0, "after_reset");

      // Randomized soak, biased toward extreme operands, with rare resets
      for (int i = 0; i < 3000; i++) begin
         x = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F) : 8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F) : 8'($urandom);
         op_sub = 1'($urandom);
         sat_en = 1'($urandom);
         start  = ($urandom_range(0, 2) == 0);
         rst_n  = ($urandom_range(0, 299) != 0);
         tick();
      end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
